// File: rtl/mean_engine_scheduler.sv
// Round-robin scheduler sharing one pipelined mean engine between several window sources.
// Results are routed back to their owner via a tag pipe that tracks the engine latency.
module mean_engine_scheduler #(
    parameter int P_NUM_REQ        = 3,
    parameter int P_WIN_WIDTH      = 1620,
    parameter int P_RES_WIDTH      = 288,
    parameter int P_ENGINE_LATENCY = 2,
    parameter int P_CNT_WIDTH      = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_enable,
    input  logic [P_NUM_REQ-1:0]             i_req_valid,
    input  logic [P_NUM_REQ*P_WIN_WIDTH-1:0] i_req_data,
    output logic [P_NUM_REQ-1:0]             o_req_ready,
    output logic                             o_eng_valid,
    output logic [P_WIN_WIDTH-1:0]           o_eng_data,
    input  logic                             i_eng_valid,
    input  logic [P_RES_WIDTH-1:0]           i_eng_data,
    output logic [P_NUM_REQ-1:0]             o_rsp_valid,
    output logic [P_RES_WIDTH-1:0]           o_rsp_data,
    output logic                             o_idle,
    output logic                             o_err,
    output logic [P_CNT_WIDTH-1:0]           o_issue_cnt
);

    localparam int ID_W   = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;
    localparam int CAND_W = ID_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      grant_id;
    logic [ID_W-1:0]      wrap_id;
    logic [CAND_W-1:0]    cand;
    logic                 grant;
    logic [P_NUM_REQ-1:0] ready;
    logic [ID_W-1:0]      issue_id;

    logic [P_ENGINE_LATENCY-1:0]           tag_valid;
    logic [P_ENGINE_LATENCY-1:0][ID_W-1:0] tag_id;
    logic [P_NUM_REQ-1:0]                  rsp_onehot;
    logic                                  in_flight;

    assign in_flight   = o_eng_valid | (|tag_valid);
    assign o_idle      = (state == IDLE) && !in_flight;
    assign o_req_ready = ready;

    // Search from the pointer, wrapping once around; first valid requester wins.
    always_comb begin
        ready    = '0;
        grant    = 1'b0;
        grant_id = '0;
        cand     = '0;
        wrap_id  = '0;
        if (state == RUN) begin
            for (int i = 0; i < P_NUM_REQ; i++) begin
                cand    = {1'b0, ptr} + CAND_W'(i);
                wrap_id = (cand >= CAND_W'(P_NUM_REQ)) ? ID_W'(cand - CAND_W'(P_NUM_REQ))
                                                       : ID_W'(cand);
                if (!grant && i_req_valid[wrap_id]) begin
                    grant    = 1'b1;
                    grant_id = wrap_id;
                end
            end
        end
        if (grant) begin
            ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_enable)   state_next = RUN;
            RUN:     if (!i_enable)  state_next = DRAIN;
            DRAIN:   if (!in_flight) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                ptr <= (grant_id == ID_W'(P_NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_eng_valid <= 1'b0;
            o_eng_data  <= '0;
            issue_id    <= '0;
            o_issue_cnt <= '0;
        end else begin
            o_eng_valid <= grant;
            o_eng_data  <= grant ? i_req_data[int'(grant_id)*P_WIN_WIDTH +: P_WIN_WIDTH] : '0;
            issue_id    <= grant_id;
            if (o_eng_valid) begin
                o_issue_cnt <= o_issue_cnt + P_CNT_WIDTH'(1);
            end
        end
    end

    // The last tag stage lines up with the engine's result for the same window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag_valid <= '0;
            tag_id    <= '0;
        end else begin
            tag_valid[0] <= o_eng_valid;
            tag_id[0]    <= issue_id;
            for (int i = 1; i < P_ENGINE_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    always_comb begin
        rsp_onehot = '0;
        rsp_onehot[tag_id[P_ENGINE_LATENCY-1]] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
            o_err       <= 1'b0;
        end else begin
            if (tag_valid[P_ENGINE_LATENCY-1] && i_eng_valid) begin
                o_rsp_valid <= rsp_onehot;
                o_rsp_data  <= i_eng_data;
            end else begin
                o_rsp_valid <= '0;
            end
            if (tag_valid[P_ENGINE_LATENCY-1] != i_eng_valid) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule
